lt_arbiter: RTL and testbench
=============================

Name: lt_arbiter

Overview:
- Shares one registered 32-bit less-than comparator (`lt`: `clk`, `a`, `b`, `z`) between N requesters.
- Round-robin arbitration grants one operand pair per cycle and drives the comparator inputs.
- Carries requester tags through the comparator latency and returns each result on a tagged result bus.
- Sits between client blocks and the single comparator instance in the math components layer.

Parameters:
- N, 4, number of requesters (2..16).
- W, 32, operand width; must match the comparator.
- CMP_LATENCY, 1, cycles from comparator input change to `z` update (the `lt` component is 1).
- TAG_W, 2, tag width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N  per-requester request valid.
- req_a  input  N*W  operand A; requester i in bits [i*W +: W].
- req_b  input  N*W  operand B, same packing as req_a.
- req_ready  output  N  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- cmp_a  output  W  registered operand A to the comparator.
- cmp_b  output  W  registered operand B to the comparator.
- cmp_z  input  1  comparator result, a < b (unsigned).
- res_valid  output  1  result strobe, one cycle per accepted request.
- res_tag  output  TAG_W  index of the requester that owns res_z.
- res_z  output  1  comparison result; meaningful only when res_valid=1.

Behaviour:
- Reset (async, rst=1): ptr=0, cmp_a=0, cmp_b=0, issue valid=0, tag pipeline valids all 0.
  - res_valid=0, res_tag=0, req_ready=0 while rst asserted.
- Arbitration (combinational from ptr and req_valid):
  - Search order starts at index ptr and ascends mod N.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - No valid requests means req_ready=0.
  - At most one grant per cycle; the arbiter never stalls, so throughput is 1 request per cycle.
- On a handshake to requester g at edge k:
  - cmp_a <= req_a[g], cmp_b <= req_b[g].
  - ptr <= (g+1) mod N.
  - tag pipeline stage 0 <= {1, g}.
- No grant at edge k: cmp_a/cmp_b hold their values, ptr holds, stage 0 valid <= 0.
- Tag pipeline: CMP_LATENCY registered stages of {valid, tag}; it shifts every cycle.
- Outputs:
  - res_valid and res_tag come from the last stage.
  - res_z = cmp_z, combinational pass-through.
- Latency: a handshake at edge k gives res_valid=1 in the cycle after edge k+CMP_LATENCY, i.e. 2 edges with the default.
- Results emerge in grant order. There is no result backpressure; requesters must always accept.
- A requester that drops req_valid before being granted loses its request silently; no ready is held for it.
- Back-to-back: requester 0 alone, valid continuously, is granted every cycle because the wrap leaves it the only candidate.
- Reset mid-operation: all in-flight results are discarded, with no res_valid for them after reset.
  - ptr restarts at 0.
  - cmp_a/cmp_b are cleared to 0; the comparator then outputs z=0.

Optional Feature:
- Macro: LT_ARBITER_STATS_EN.
- When defined:
  - Adds output port grant_count (N*16); counter i is in bits [i*16 +: 16].
  - Counter i increments on each handshake with requester i and saturates at 16'hFFFF.
  - Counters clear to 0 on rst.
  - Adds input stats_clr (1); a synchronous clear that takes precedence over a same-cycle increment.
- When undefined: neither port exists and there are no counter flops. Arbitration and timing are identical in both builds.

Decomposition:
- Shared package lt_arbiter_pkg holds:
  - constants LT_W=32, LT_CMP_LATENCY=1, STAT_W=16;
  - the {valid, tag} pipeline stage typedef.
- One sub-module: rr_pick (combinational round-robin one-hot picker).
  - Inputs: request vector, ptr.
  - Outputs: one-hot grant, encoded index.
- The comparator stays an external instance wired by the parent.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst 3 cycles, then release with all req_valid=0.
  - Required: req_ready=0, res_valid=0, cmp_a=cmp_b=0 throughout.
- Single request:
  - Stimulus: requester 2 with a=5, b=9, valid 1 cycle.
  - Required: req_ready=4'b0100; two edges later res_valid=1, res_tag=2, res_z=1, for exactly one cycle.
- Round-robin fairness:
  - Stimulus: all four valid continuously with a=i, b=2 (requester i).
  - Required: grants 0,1,2,3,0,...; results in that order with res_z=1,1,0,0.
- Equal and extreme operands:
  - Stimulus: requester 1 with a=b=32'hFFFFFFFF, then requester 3 with a=0, b=32'hFFFFFFFF.
  - Required: res_z=0 (tag 1), then res_z=1 (tag 3).
- Reset mid-flight:
  - Stimulus: grant requester 1, assert rst on the following cycle.
  - Required: no res_valid for that request; first grant after reset goes to requester 0 when all are valid.
- Stats build (LT_ARBITER_STATS_EN):
  - Stimulus: 5 grants to requester 0, then stats_clr coincident with a 6th grant.
  - Required: grant_count[15:0] reads 5, then 0.

Source files
------------

// File: rtl/lt_arbiter_pkg.sv
// Shared constants and the {valid, tag} pipeline stage type for lt_arbiter.
// Tags are stored at the widest supported width (N up to 16) and narrowed by the user.
package lt_arbiter_pkg;

  localparam int LT_W           = 32;
  localparam int LT_CMP_LATENCY = 1;
  localparam int STAT_W         = 16;
  localparam int TAG_MAX_W      = 4;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_stage_t;

endpackage

// File: rtl/lt_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i (mod N)
// wins; returns a one-hot grant, its encoded index and an any-grant flag.
module rr_pick #(
  parameter int N     = 4,
  parameter int TAG_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [TAG_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [TAG_W-1:0] idx_o,
  output logic             any_o
);

  localparam int             PW  = 1 << TAG_W;
  localparam logic [TAG_W:0] N_L = (TAG_W+1)'(N);

  logic [PW-1:0]  req_pad;
  logic [PW-1:0]  gnt_pad;
  logic [TAG_W:0] pos;
  logic           found;
  logic           unused_pad;

  // Request vector is padded to a power of two so the wrapped position indexes it directly.
  always_comb begin
    req_pad          = '0;
    req_pad[N-1:0]   = req_i;
    gnt_pad          = '0;
    idx_o            = '0;
    found            = 1'b0;
    pos              = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (TAG_W+1)'(k);
      if (pos >= N_L) pos = pos - N_L;
      if (!found && req_pad[pos[TAG_W-1:0]]) begin
        found                    = 1'b1;
        gnt_pad[pos[TAG_W-1:0]]  = 1'b1;
        idx_o                    = pos[TAG_W-1:0];
      end
    end
  end

  assign gnt_o      = gnt_pad[N-1:0];
  assign any_o      = found;
  assign unused_pad = ^gnt_pad;

endmodule

// File: rtl/lt_arbiter.sv
// Round-robin sharing of one registered less-than comparator among N requesters,
// with tags carried alongside the comparator latency. LT_ARBITER_STATS_EN adds grant counters.
module lt_arbiter
  import lt_arbiter_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = LT_W,
  parameter int CMP_LATENCY = LT_CMP_LATENCY,
  parameter int TAG_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic [W-1:0]     cmp_a,
  output logic [W-1:0]     cmp_b,
  input  logic             cmp_z,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_z
`ifdef LT_ARBITER_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [N*STAT_W-1:0] grant_count
`endif
);

  // Handshake: requester i transfers on a cycle where req_valid[i] & req_ready[i];
  // req_ready is combinational, one-hot, never held for a requester that drops valid,
  // and results return without backpressure.

  logic [N-1:0]     gnt;
  logic [TAG_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             hs;

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]     cmp_a_q, cmp_b_q;
  logic [W-1:0]     sel_a, sel_b;
  tag_stage_t       issue_q;
  tag_stage_t       pipe_q [CMP_LATENCY];
  tag_stage_t       last_stage;
  logic             unused_tag;

  rr_pick #(
    .N     (N),
    .TAG_W (TAG_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign hs        = gnt_any & ~rst;
  assign req_ready = rst ? '0 : gnt;
  assign ptr_d     = (gnt_idx == TAG_W'(N-1)) ? '0 : gnt_idx + TAG_W'(1);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // issue_q tracks the pair sitting on the comparator inputs; pipe_q follows the
  // comparator's own latency so the tag lines up with cmp_z.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      cmp_a_q <= '0;
      cmp_b_q <= '0;
      issue_q <= '0;
      for (int i = 0; i < CMP_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      if (hs) begin
        ptr_q   <= ptr_d;
        cmp_a_q <= sel_a;
        cmp_b_q <= sel_b;
        issue_q <= '{valid: 1'b1, tag: TAG_MAX_W'(gnt_idx)};
      end else begin
        issue_q <= '0;
      end
      pipe_q[0] <= issue_q;
      for (int i = 1; i < CMP_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign last_stage = pipe_q[CMP_LATENCY-1];
  assign cmp_a      = cmp_a_q;
  assign cmp_b      = cmp_b_q;
  assign res_valid  = last_stage.valid;
  assign res_tag    = last_stage.tag[TAG_W-1:0];
  assign res_z      = cmp_z;
  assign unused_tag = ^last_stage.tag;

`ifdef LT_ARBITER_STATS_EN
  logic [STAT_W-1:0] cnt_q [N];

  // Synchronous clear wins over a same-cycle grant; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hs && gnt[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + STAT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_cnt
    assign grant_count[gi*STAT_W +: STAT_W] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_lt_arbiter.sv
// Bench for lt_arbiter: directed scenarios plus random traffic against a queue-based
// reference model; covers the LT_ARBITER_STATS_EN counters when that macro is defined.
module tb_lt_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     cmp_a, cmp_b;
  logic             cmp_z;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_z;
`ifdef LT_ARBITER_STATS_EN
  logic             stats_clr = 1'b0;
  logic [N*16-1:0]  grant_count;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  // external registered comparator
  always @(posedge clk) cmp_z <= (cmp_a < cmp_b);

  lt_arbiter #(.N(N), .W(W), .CMP_LATENCY(1), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_z     (cmp_z),
    .res_valid (res_valid),
    .res_tag   (res_tag),
    .res_z     (res_z)
`ifdef LT_ARBITER_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .grant_count (grant_count)
`endif
  );

  // reference model state
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  int          ptr_m = 0;
  logic [W-1:0] exp_cmp_a = '0;
  logic [W-1:0] exp_cmp_b = '0;
  logic [4:0]  exp_q[$];
  int          due_q[$];
  int          cnt_m[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                           input logic [W-1:0] x2, input logic [W-1:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return W'($urandom);
      1:       return '0;
      2:       return '1;
      default: return W'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic check_stats();
`ifdef LT_ARBITER_STATS_EN
    logic [N*16-1:0] exp_gc;
    for (int i = 0; i < N; i++) exp_gc[i*16 +: 16] = 16'(cnt_m[i]);
    chk("grant_count", grant_count, exp_gc);
`endif
  endtask

  task automatic check_results();
    logic [4:0] e;
    if (due_q.size() > 0 && due_q[0] == edge_cnt) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      chk("res_valid", res_valid, 1);
      chk("res_tag", res_tag, e[4:1]);
      chk("res_z", res_z, e[0]);
    end else begin
      chk("res_valid_idle", res_valid, 0);
    end
  endtask

  // driver: applies one cycle of requests, predicts grant/result, checks after the edge
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    int g;
    logic [N-1:0] exp_rdy;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      exp_cmp_a = a[g*W +: W];
      exp_cmp_b = b[g*W +: W];
      exp_q.push_back({4'(g), exp_cmp_a < exp_cmp_b});
      due_q.push_back(edge_cnt + 2);
      ptr_m = (g + 1) % N;
    end
`ifdef LT_ARBITER_STATS_EN
    if (stats_clr) begin
      for (int i = 0; i < N; i++) cnt_m[i] = 0;
    end else if (g >= 0 && cnt_m[g] < 65535) begin
      cnt_m[g]++;
    end
`endif
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    chk("cmp_a", cmp_a, exp_cmp_a);
    chk("cmp_b", cmp_b, exp_cmp_b);
    check_results();
    check_stats();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    req_valid = '0;
    exp_q.delete();
    due_q.delete();
    ptr_m     = 0;
    exp_cmp_a = '0;
    exp_cmp_b = '0;
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    repeat (n) begin
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_tag", res_tag, 0);
      chk("rst_cmp_a", cmp_a, 0);
      chk("rst_cmp_b", cmp_b, 0);
      check_stats();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) cnt_m[i] = 0;

    // reset and idle
    do_reset(3);
    idle(3);

    // single request from requester 2: 5 < 9
    cycle(4'b0100, pack4(0, 0, 5, 0), pack4(0, 0, 9, 0));
    idle(3);

    // round-robin fairness: a=i, b=2
    do_reset(1);
    repeat (8) cycle(4'b1111, pack4(0, 1, 2, 3), pack4(2, 2, 2, 2));
    idle(3);

    // equal and extreme operands
    cycle(4'b0010, pack4(0, 32'hFFFF_FFFF, 0, 0), pack4(0, 32'hFFFF_FFFF, 0, 0));
    cycle(4'b1000, pack4(0, 0, 0, 0), pack4(0, 0, 0, 32'hFFFF_FFFF));
    idle(3);

    // reset while a result is in flight
    do_reset(1);
    cycle(4'b0010, pack4(0, 7, 0, 0), pack4(0, 3, 0, 0));
    do_reset(2);
    cycle(4'b1111, pack4(1, 2, 3, 4), pack4(4, 3, 2, 1));
    idle(3);

`ifdef LT_ARBITER_STATS_EN
    // counters: five grants, then a clear coincident with a sixth grant
    do_reset(1);
    repeat (5) cycle(4'b0001, pack4(1, 0, 0, 0), pack4(2, 0, 0, 0));
    chk("grant_count0_five", grant_count[15:0], 5);
    stats_clr = 1'b1;
    cycle(4'b0001, pack4(1, 0, 0, 0), pack4(2, 0, 0, 0));
    stats_clr = 1'b0;
    chk("grant_count0_clr", grant_count[15:0], 0);
    idle(2);
`endif

    // requester 0 alone is granted back to back
    do_reset(1);
    repeat (4) cycle(4'b0001, pack4(3, 0, 0, 0), pack4(9, 0, 0, 0));
    idle(2);

    // random traffic with occasional resets
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1);
      end else begin
        cycle(N'($urandom_range(0, (1 << N) - 1)),
              pack4(rand_op(), rand_op(), rand_op(), rand_op()),
              pack4(rand_op(), rand_op(), rand_op(), rand_op()));
      end
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
